// File: rtl/nibbler_pkg.sv
// Shared types and ALU control encodings for the Nibbler execution controller.
package nibbler_pkg;

  localparam int unsigned NIB_W  = 4;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_LIT  = 4'h1,
    OP_ADD  = 4'h2,
    OP_NOR  = 4'h3,
    OP_CMP  = 4'h4,
    OP_OUT  = 4'h5,
    OP_JMP  = 4'h6,
    OP_JC   = 4'h7,
    OP_JZ   = 4'h8,
    OP_HALT = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    ST_FETCH   = 3'd0,
    ST_WAIT    = 3'd1,
    ST_DECODE  = 3'd2,
    ST_EXECUTE = 3'd3,
    ST_FETCH2  = 3'd4,
    ST_WAIT2   = 3'd5,
    ST_HALTED  = 3'd6
  } state_e;

  typedef struct packed {
    logic             notCarryIn;
    logic             mode;
    logic [NIB_W-1:0] func;
  } aluCtrl_t;

  localparam aluCtrl_t ALU_APASS = '{notCarryIn: 1'b1, mode: 1'b0, func: 4'b0000};
  localparam aluCtrl_t ALU_BPASS = '{notCarryIn: 1'b1, mode: 1'b1, func: 4'b1010};
  localparam aluCtrl_t ALU_ADD   = '{notCarryIn: 1'b1, mode: 1'b0, func: 4'b1001};
  localparam aluCtrl_t ALU_NOR   = '{notCarryIn: 1'b1, mode: 1'b1, func: 4'b0001};
  localparam aluCtrl_t ALU_CMP   = '{notCarryIn: 1'b0, mode: 1'b0, func: 4'b0110};

endpackage

// File: rtl/nibbler_decode.sv
// Combinational instruction decode: IR byte to ALU controls and writeback enables.
module nibbler_decode
  import nibbler_pkg::*;
(
  input  logic [BYTE_W-1:0] ir,
  output aluCtrl_t          aluCtrl,
  output logic              writeAcc,
  output logic              writeCarry,
  output logic              writeZero,
  output logic              isJump,
  output logic              isHalt,
  output logic              isOut
);

  always_comb begin
    aluCtrl    = ALU_APASS;
    writeAcc   = 1'b0;
    writeCarry = 1'b0;
    writeZero  = 1'b0;
    isJump     = 1'b0;
    isHalt     = 1'b0;
    isOut      = 1'b0;
    // Opcodes 9..E fall through to default and behave as NOP
    case (ir[7:4])
      OP_LIT: begin
        aluCtrl   = ALU_BPASS;
        writeAcc  = 1'b1;
        writeZero = 1'b1;
      end
      OP_ADD: begin
        aluCtrl    = ALU_ADD;
        writeAcc   = 1'b1;
        writeCarry = 1'b1;
        writeZero  = 1'b1;
      end
      OP_NOR: begin
        aluCtrl   = ALU_NOR;
        writeAcc  = 1'b1;
        writeZero = 1'b1;
      end
      OP_CMP: begin
        aluCtrl    = ALU_CMP;
        writeCarry = 1'b1;
        writeZero  = 1'b1;
      end
      OP_OUT:                isOut  = 1'b1;
      OP_JMP, OP_JC, OP_JZ:  isJump = 1'b1;
      OP_HALT:               isHalt = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/nibbler_exec_ctrl.sv
// Nibbler fetch/decode/execute controller driving the external 4-bit ALU.
// Optional NIBBLER_SINGLE_STEP_EN adds stepReq to gate each instruction fetch.
module nibbler_exec_ctrl
  import nibbler_pkg::*;
#(
  parameter int unsigned          PC_WIDTH = 8,
  parameter logic [PC_WIDTH-1:0]  RESET_PC = '0
) (
  input  logic                clock,
  input  logic                notReset,
  output logic [PC_WIDTH-1:0] romAddr,
  output logic                romReq,
  input  logic                romAck,
  input  logic [BYTE_W-1:0]   romData,
  output logic                aluNotCarryIn,
  output logic                aluMode,
  output logic [NIB_W-1:0]    aluFunc,
  output logic [NIB_W-1:0]    aluA,
  output logic [NIB_W-1:0]    aluB,
  input  logic [NIB_W-1:0]    aluData,
  input  logic                aluCarry,
  input  logic                aluZero,
  output logic [NIB_W-1:0]    outData,
  output logic                outValid,
  output logic                halted
`ifdef NIBBLER_SINGLE_STEP_EN
  ,
  input  logic                stepReq
`endif
);

  localparam logic [2:0] FETCH   = ST_FETCH;
  localparam logic [2:0] WAIT    = ST_WAIT;
  localparam logic [2:0] DECODE  = ST_DECODE;
  localparam logic [2:0] EXECUTE = ST_EXECUTE;
  localparam logic [2:0] FETCH2  = ST_FETCH2;
  localparam logic [2:0] WAIT2   = ST_WAIT2;
  localparam logic [2:0] HALTED  = ST_HALTED;

  logic [2:0]          state, stateNext;
  logic [PC_WIDTH-1:0] pc, pcNext, pcInc, romAddrNext;
  logic [NIB_W-1:0]    acc, accNext, outDataNext;
  logic [BYTE_W-1:0]   ir, irNext;
  logic                carryFlag, carryNext, zeroFlag, zeroNext;
  logic                romReqNext, outValidNext, haltedNext;
  logic                stepGo, jumpTaken;

  aluCtrl_t decCtrl, aluCtrlC;
  logic     writeAcc, writeCarry, writeZero, isJump, isHalt, isOut;

  nibbler_decode uDecode (
    .ir         (ir),
    .aluCtrl    (decCtrl),
    .writeAcc   (writeAcc),
    .writeCarry (writeCarry),
    .writeZero  (writeZero),
    .isJump     (isJump),
    .isHalt     (isHalt),
    .isOut      (isOut)
  );

`ifdef NIBBLER_SINGLE_STEP_EN
  assign stepGo = stepReq;
`else
  assign stepGo = 1'b1;
`endif

  assign pcInc     = pc + PC_WIDTH'(1);
  assign jumpTaken = (ir[7:4] == OP_JMP) ||
                     ((ir[7:4] == OP_JC) && carryFlag) ||
                     ((ir[7:4] == OP_JZ) && zeroFlag);

  // ALU sees decoded controls only while an instruction is executing
  assign aluCtrlC      = (state == EXECUTE) ? decCtrl : ALU_APASS;
  assign aluNotCarryIn = aluCtrlC.notCarryIn;
  assign aluMode       = aluCtrlC.mode;
  assign aluFunc       = aluCtrlC.func;
  assign aluA          = acc;
  assign aluB          = ir[3:0];

  always_comb begin
    stateNext    = state;
    pcNext       = pc;
    accNext      = acc;
    carryNext    = carryFlag;
    zeroNext     = zeroFlag;
    irNext       = ir;
    romReqNext   = romReq;
    romAddrNext  = romAddr;
    outDataNext  = outData;
    outValidNext = 1'b0;
    haltedNext   = halted;
    case (state)
      FETCH: begin
        if (stepGo) begin
          romReqNext  = 1'b1;
          romAddrNext = pc;
          stateNext   = WAIT;
        end
      end
      WAIT: begin
        if (romAck) begin
          romReqNext = 1'b0;
          irNext     = romData;
          pcNext     = pcInc;
          stateNext  = DECODE;
        end
      end
      DECODE: begin
        if (isJump) begin
          stateNext = FETCH2;
        end else if (isHalt) begin
          haltedNext = 1'b1;
          stateNext  = HALTED;
        end else begin
          stateNext = EXECUTE;
        end
      end
      EXECUTE: begin
        if (writeAcc)   accNext   = aluData;
        if (writeCarry) carryNext = aluCarry;
        if (writeZero)  zeroNext  = aluZero;
        if (isOut) begin
          outDataNext  = acc;
          outValidNext = 1'b1;
        end
        stateNext = FETCH;
      end
      FETCH2: begin
        romReqNext  = 1'b1;
        romAddrNext = pc;
        stateNext   = WAIT2;
      end
      WAIT2: begin
        if (romAck) begin
          romReqNext = 1'b0;
          pcNext     = jumpTaken ? PC_WIDTH'(romData) : pcInc;
          stateNext  = FETCH;
        end
      end
      HALTED: ;
      default: stateNext = FETCH;
    endcase
  end

  always_ff @(posedge clock or negedge notReset) begin
    if (!notReset) begin
      state     <= FETCH;
      pc        <= RESET_PC;
      acc       <= '0;
      carryFlag <= 1'b0;
      zeroFlag  <= 1'b0;
      ir        <= '0;
      romReq    <= 1'b0;
      romAddr   <= RESET_PC;
      outData   <= '0;
      outValid  <= 1'b0;
      halted    <= 1'b0;
    end else begin
      state     <= stateNext;
      pc        <= pcNext;
      acc       <= accNext;
      carryFlag <= carryNext;
      zeroFlag  <= zeroNext;
      ir        <= irNext;
      romReq    <= romReqNext;
      romAddr   <= romAddrNext;
      outData   <= outDataNext;
      outValid  <= outValidNext;
      halted    <= haltedNext;
    end
  end

endmodule
